core_idq: RTL and testbench

CORE_IDQ -- requirements
Module: core_idq

---
 rtl/core_idq.sv | 163 ++++++++++++++++
 tb/tb_core_idq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/core_idq.sv
// Decode queue: DEPTH-entry FIFO of {pc, instr} with head decode; push-to-head latency 1 cycle, if_ready=0 when full.
// Flush/reset drop all entries; optional CORE_IDQ_ERR_EN flags undefined opcodes on fire.
module core_idq #(
    parameter int DEPTH    = 2,
    parameter int WB_PORTS = 2,
    parameter int IMM_W    = 11
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            if_valid,
    output logic                            if_ready,
    input  logic [31:0]                     if_pc,
    input  logic [31:0]                     if_instr,
    input  logic                            id_flush,
    input  logic                            ex_ready,
    input  logic [WB_PORTS*4-1:0]           wb_addr,
    input  logic [WB_PORTS-1:0]             wb_valid,
    input  logic [2:0]                      flag,
    output logic                            id_valid,
    output logic [31:0]                     id_pc,
    output logic [31:0]                     id_instr,
    output logic [31:0]                     imm,
    output logic [3:0]                      rega_addr,
    output logic [3:0]                      regb_addr,
    output logic [$clog2(WB_PORTS+3)-1:0]   opmux_a,
    output logic [$clog2(WB_PORTS+3)-1:0]   opmux_b,
    output logic                            branch,
    output logic                            branch_imm,
    output logic                            branch_abs,
    output logic                            swi,
    output logic                            rfe,
    output logic                            wb_spr,
    output logic                            id_err,
    output logic [3:0]                      spr_addr
);
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int SEL_W = $clog2(WB_PORTS + 3);

    localparam logic [5:0] OPCODE_NOP  = 6'h00;
    localparam logic [5:0] OPCODE_ADD  = 6'h01;
    localparam logic [5:0] OPCODE_MOV  = 6'h02;
    localparam logic [5:0] OPCODE_B    = 6'h03;
    localparam logic [5:0] OPCODE_CALL = 6'h04;
    localparam logic [5:0] OPCODE_RET  = 6'h05;
    localparam logic [5:0] OPCODE_SWI  = 6'h06;
    localparam logic [5:0] OPCODE_RFE  = 6'h07;
    localparam logic [5:0] OPCODE_LD   = 6'h08;
    localparam logic [5:0] OPCODE_ST   = 6'h09;
    localparam logic [3:0] RF_PC       = 4'd15;

    logic [31:0]   mem_pc    [DEPTH];
    logic [31:0]   mem_instr [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   last_pc;
    logic          marker;
    logic          push, fire;

    logic [5:0]    opcode;
    logic [3:0]    regd_cond;
    logic          imm_i, imm_s;

    assign if_ready = (count != CW'(DEPTH));
    assign id_valid = (count != '0);
    // Flush wins over both handshakes: nothing enters, nothing retires.
    assign push     = if_valid && if_ready && !id_flush;
    assign fire     = id_valid && ex_ready && !id_flush;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]    <= if_pc;
            mem_instr[wr_ptr] <= if_instr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            last_pc <= '0;
            marker  <= 1'b0;
        end else if (id_flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            marker  <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (fire) begin
                rd_ptr  <= rd_ptr + 1'b1;
                last_pc <= mem_pc[rd_ptr];
            end
            if (push && !fire)      count <= count + 1'b1;
            else if (fire && !push) count <= count - 1'b1;
        end
    end

    // Empty head presents a NOP whose payload records whether the last clear was a flush.
    assign id_pc    = id_valid ? mem_pc[rd_ptr] : last_pc;
    assign id_instr = id_valid ? mem_instr[rd_ptr] : {OPCODE_NOP, 25'd0, marker};

    assign opcode    = id_instr[31:26];
    assign regd_cond = id_instr[25:22];
    assign rega_addr = id_instr[21:18];
    assign regb_addr = id_instr[17:14];
    assign imm_i     = id_instr[13];
    assign imm_s     = id_instr[12];

    always_comb begin
        imm = '0;
        if (imm_i) begin
            if (imm_s) imm = {{(32-IMM_W){id_instr[IMM_W-1]}}, id_instr[IMM_W-1:0]};
            else       imm = {{(32-IMM_W){1'b0}}, id_instr[IMM_W-1:0]};
        end
    end

    // Descending scan so the lowest matching writeback port is assigned last and wins.
    always_comb begin
        opmux_a = (rega_addr == RF_PC) ? SEL_W'(1) : SEL_W'(0);
        opmux_b = (regb_addr == RF_PC) ? SEL_W'(1) : SEL_W'(0);
        for (int k = WB_PORTS - 1; k >= 0; k--) begin
            if (wb_valid[k] && (wb_addr[k*4 +: 4] == rega_addr)) opmux_a = SEL_W'(2 + k);
            if (wb_valid[k] && (wb_addr[k*4 +: 4] == regb_addr)) opmux_b = SEL_W'(2 + k);
        end
        if (imm_i) opmux_b = SEL_W'(WB_PORTS + 2);
    end

    assign branch_imm = imm_i;
    assign branch_abs = regb_addr[0];
    assign spr_addr   = regd_cond;

    always_comb begin
        branch = 1'b0;
        swi    = 1'b0;
        rfe    = 1'b0;
        wb_spr = 1'b0;
        if (fire) begin
            branch = ((opcode == OPCODE_B) && (regd_cond[2:0] == flag))
                     || (opcode == OPCODE_CALL) || (opcode == OPCODE_RET);
            swi    = (opcode == OPCODE_SWI);
            rfe    = (opcode == OPCODE_RFE);
            wb_spr = (opcode == OPCODE_MOV) && regb_addr[1];
        end
    end

`ifdef CORE_IDQ_ERR_EN
    always_comb begin
        id_err = 1'b0;
        if (fire) begin
            case (opcode)
                OPCODE_NOP, OPCODE_ADD, OPCODE_MOV, OPCODE_B, OPCODE_CALL,
                OPCODE_RET, OPCODE_SWI, OPCODE_RFE, OPCODE_LD, OPCODE_ST: id_err = 1'b0;
                default: id_err = 1'b1;
            endcase
        end
    end
`else
    assign id_err = 1'b0;
`endif

endmodule

// File: tb/tb_core_idq.sv
// Scoreboard bench for core_idq: expected entries queued on push, compared at head and on fire.
module tb_core_idq;
    localparam int DEPTH    = 2;
    localparam int WB_PORTS = 2;
    localparam int IMM_W    = 11;
    localparam int SEL_W    = $clog2(WB_PORTS + 3);

    localparam logic [5:0] OP_NOP = 6'h00, OP_ADD = 6'h01, OP_MOV = 6'h02, OP_B = 6'h03,
                           OP_CALL = 6'h04, OP_RET = 6'h05, OP_SWI = 6'h06, OP_RFE = 6'h07;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic if_valid = 1'b0, id_flush = 1'b0, ex_ready = 1'b0;
    logic [31:0] if_pc = '0, if_instr = '0;
    logic [WB_PORTS*4-1:0] wb_addr = '0;
    logic [WB_PORTS-1:0] wb_valid = '0;
    logic [2:0] flag = '0;
    logic if_ready, id_valid, branch, branch_imm, branch_abs, swi, rfe, wb_spr, id_err;
    logic [31:0] id_pc, id_instr, imm;
    logic [3:0] rega_addr, regb_addr, spr_addr;
    logic [SEL_W-1:0] opmux_a, opmux_b;

    core_idq #(.DEPTH(DEPTH), .WB_PORTS(WB_PORTS), .IMM_W(IMM_W)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
        .if_instr(if_instr), .id_flush(id_flush), .ex_ready(ex_ready), .wb_addr(wb_addr),
        .wb_valid(wb_valid), .flag(flag), .id_valid(id_valid), .id_pc(id_pc),
        .id_instr(id_instr), .imm(imm), .rega_addr(rega_addr), .regb_addr(regb_addr),
        .opmux_a(opmux_a), .opmux_b(opmux_b), .branch(branch), .branch_imm(branch_imm),
        .branch_abs(branch_abs), .swi(swi), .rfe(rfe), .wb_spr(wb_spr), .id_err(id_err),
        .spr_addr(spr_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] pc; logic [31:0] instr; } entry_t;
    entry_t q[$];
    logic [31:0] m_last_pc = '0;
    logic        m_marker  = 1'b0;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [3:0] rd, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic i, input logic s,
                                       input logic [10:0] iv);
        return {op, rd, ra, rb, i, s, 1'b0, iv};
    endfunction

    function automatic int fwd_sel(input logic [3:0] r);
        for (int k = 0; k < WB_PORTS; k++)
            if (wb_valid[k] && wb_addr[k*4 +: 4] == r) return 2 + k;
        return (r == 4'd15) ? 1 : 0;
    endfunction

    function automatic logic legal_op(input logic [5:0] op);
        return op <= 6'h09;
    endfunction

    // One cycle: drive at negedge, check against the model, then advance the model.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic er, input logic fl);
        logic [31:0] h, e_imm, mask;
        logic [5:0]  op;
        logic        nonempty, fire, e_br, e_err;
        @(negedge clk);
        if_valid = v; if_pc = pc; if_instr = ins; ex_ready = er; id_flush = fl;
        #1;
        nonempty = (q.size() != 0);
        check("if_ready", if_ready, q.size() < DEPTH);
        check("id_valid", id_valid, nonempty);
        h = nonempty ? q[0].instr : {OP_NOP, 25'd0, m_marker};
        check("id_instr", id_instr, h);
        check("id_pc", id_pc, nonempty ? q[0].pc : m_last_pc);
        op = h[31:26];
        mask = (32'd1 << IMM_W) - 1;
        e_imm = '0;
        if (h[13]) begin
            e_imm = h & mask;
            if (h[12] && h[IMM_W-1]) e_imm = e_imm | ~mask;
        end
        check("imm", imm, e_imm);
        check("rega", rega_addr, h[21:18]);
        check("regb", regb_addr, h[17:14]);
        check("opmux_a", opmux_a, fwd_sel(h[21:18]));
        check("opmux_b", opmux_b, h[13] ? WB_PORTS + 2 : fwd_sel(h[17:14]));
        check("branch_imm", branch_imm, h[13]);
        check("branch_abs", branch_abs, h[14]);
        check("spr_addr", spr_addr, h[25:22]);
        fire = nonempty && er && !fl;
        e_br = fire && ((op == OP_B && h[24:22] == flag) || op == OP_CALL || op == OP_RET);
        check("branch", branch, e_br);
        check("swi", swi, fire && op == OP_SWI);
        check("rfe", rfe, fire && op == OP_RFE);
        check("wb_spr", wb_spr, fire && op == OP_MOV && h[15]);
`ifdef CORE_IDQ_ERR_EN
        e_err = fire && !legal_op(op);
`else
        e_err = 1'b0;
`endif
        check("id_err", id_err, e_err);
        if (fl) begin
            q.delete();
            m_marker = 1'b1;
        end else begin
            logic can_push;
            can_push = q.size() < DEPTH;
            if (fire) begin
                m_last_pc = q[0].pc;
                void'(q.pop_front());
            end
            if (v && can_push) q.push_back('{pc: pc, instr: ins});
        end
    endtask

    initial begin
        logic [31:0] r;
        #3;
        check("rst_id_valid", id_valid, 1'b0);
        check("rst_if_ready", if_ready, 1'b1);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_id_instr", id_instr, 32'h0);
        @(negedge clk); rst = 1'b1;

        // Fill: third push held off by if_ready
        step(1, 32'h100, mk(OP_ADD, 1, 2, 3, 0, 0, 0), 0, 0);
        step(1, 32'h104, mk(OP_ADD, 4, 5, 6, 0, 0, 0), 0, 0);
        step(1, 32'h108, mk(OP_ADD, 7, 8, 9, 0, 0, 0), 0, 0);
        check("fill_if_ready", if_ready, 1'b0);
        step(1, 32'h108, mk(OP_ADD, 7, 8, 9, 0, 0, 0), 0, 0);

        // Stream: one fire per cycle, pointers wrap
        for (int n = 0; n < 8; n++)
            step(1, 32'h200 + 4 * n, mk(OP_ADD, 4'(n), 4'(n + 1), 4'(n + 2), 0, 0, 0), 1, 0);
        while (q.size() != 0) step(0, 0, 0, 1, 0);

        // Branch with ex_ready toggling
        flag = 3'd5;
        step(1, 32'h300, mk(OP_B, 4'b0101, 0, 0, 1, 0, 11'h10), 0, 0);
        step(1, 32'h304, mk(OP_B, 4'b0101, 0, 0, 1, 0, 11'h20), 0, 0);
        check("br_held", branch, 1'b0);
        step(0, 0, 0, 1, 0);
        check("br_fire", branch, 1'b1);
        step(0, 0, 0, 0, 0);
        flag = 3'd4;
        step(0, 0, 0, 1, 0);
        check("br_flag_miss", branch, 1'b0);

        // Forwarding and immediate at head
        wb_addr = {4'd3, 4'd3}; wb_valid = 2'b11;
        step(1, 32'h400, mk(OP_ADD, 0, 3, 3, 1, 1, 11'h400), 0, 0);
        step(0, 0, 0, 0, 0);
        check("fwd_opmux_a", opmux_a, 2);
        check("imm_opmux_b", opmux_b, 4);
        check("imm_sext", imm, 32'hFFFFFC00);
        step(0, 0, 0, 1, 0);
        step(1, 32'h404, mk(OP_ADD, 0, 15, 3, 1, 0, 11'h400), 0, 0);
        wb_valid = 2'b10;
        step(0, 0, 0, 0, 0);
        check("imm_zext", imm, 32'h00000400);
        check("pc_opmux_a", opmux_a, 1);
        step(0, 0, 0, 1, 0);

        // Flush with full queue and concurrent push
        step(1, 32'h500, mk(OP_SWI, 0, 0, 0, 0, 0, 0), 0, 0);
        step(1, 32'h504, mk(OP_RFE, 0, 0, 0, 0, 0, 0), 0, 0);
        step(1, 32'h508, mk(OP_ADD, 0, 0, 0, 0, 0, 0), 0, 1);
        step(0, 0, 0, 1, 0);
        check("flush_id_valid", id_valid, 1'b0);
        check("flush_marker", id_instr, 32'h00000001);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            r = $urandom;
            flag = 3'($urandom_range(0, 7));
            wb_addr = 8'($urandom); wb_valid = 2'($urandom);
            step(1'($urandom_range(0, 3) != 0), 32'h1000 + 4 * n,
                 {6'($urandom_range(0, 13)), r[25:0]}, 1'($urandom_range(0, 2) != 0),
                 $urandom_range(0, 20) == 0);
        end

        // Reset mid-transfer
        step(1, 32'h600, mk(OP_CALL, 0, 0, 0, 0, 0, 0), 0, 0);
        step(1, 32'h604, mk(OP_RET, 0, 0, 0, 0, 0, 0), 0, 0);
        @(negedge clk);
        if_valid = 1'b0; ex_ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("arst_id_valid", id_valid, 1'b0);
        check("arst_if_ready", if_ready, 1'b1);
        check("arst_id_pc", id_pc, 32'h0);
        check("arst_id_instr", id_instr, 32'h0);
        q.delete(); m_last_pc = '0; m_marker = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        check("rel_branch", branch, 1'b0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
